// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave transmitter.
// Holds the controller state encoding and the SCK edge-role selection
// derived from the clock polarity/phase parameters.
package spi_pkg;

    // Controller states: IDLE while slave select is inactive, ACTIVE during a frame.
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    // The leading SCK edge is rising when the idle level is low.
    function automatic bit leading_is_rise(input bit cpol);
        return !cpol;
    endfunction

    // The sample edge is the leading edge when CPHA=0, the trailing edge otherwise.
    // Working through the four modes, sampling lands on the rising edge exactly
    // when CPOL equals CPHA; the launch edge is always the opposite one.
    function automatic bit sample_on_rise(input bit cpol, input bit cpha);
        return (leading_is_rise(cpol) == !cpha);
    endfunction

endpackage

// File: rtl/spi_tx_fifo.sv
// Transmit FIFO for the SPI slave: single clock, power-of-two depth,
// first-word-fall-through read port and an occupancy output.
module spi_tx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          wr_en,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    assign full    = (level == FULL_LVL);
    assign empty   = (level == '0);
    assign push    = wr_en & ~full;
    assign pop     = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage array: written on accepted pushes only.
    // NOTE: the array has no reset -- a flush only needs the pointers and level
    // cleared, and leaving the RAM unreset lets it map onto memory primitives.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the level unchanged.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_slave_tx.sv
// SPI slave transmitter: synchronises SCK/SSEL into the clk domain, detects
// sample/launch edges, and shifts words from a transmit FIFO onto MISO.
// An empty FIFO at load time sends IDLE_FILL and raises a sticky underrun flag.
module spi_slave_tx
    import spi_pkg::*;
#(
    parameter int              DATA_W     = 8,
    parameter int              FIFO_DEPTH = 4,
    parameter bit              CPOL       = 1'b0,
    parameter bit              CPHA       = 1'b0,
    parameter bit              MSB_FIRST  = 1'b1,
    parameter logic [DATA_W-1:0] IDLE_FILL = '1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        SCK,
    input  logic                        SSEL,
    output logic                        MISO,
    output logic                        MISO_oe,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    output logic                        word_sent,
    output logic                        underrun,
    input  logic                        clr_underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int               CNT_W       = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DATA_W - 1);
    localparam bit               SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

    spi_state_t        state;
    spi_state_t        state_nxt;
    logic [2:0]        sck_sync;
    logic [2:0]        ssel_sync;
    logic              sck_rise;
    logic              sck_fall;
    logic              ssel_rise;
    logic              ssel_fall;
    logic              sample_edge;
    logic              launch_edge;
    logic [CNT_W-1:0]  bit_cnt;
    logic              pending_load;
    logic [DATA_W-1:0] shreg;
    logic              load_req;
    logic              shift_req;
    logic              cnt_clr;
    logic              cnt_inc;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_full;
    logic              fifo_empty;

    spi_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_data (wr_data),
        .wr_en   (wr_valid),
        .rd_en   (load_req),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign wr_ready = ~fifo_full;

    // Three-stage synchronisers; reset to the pins' idle levels so no false edge follows reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync  <= {3{CPOL}};
            ssel_sync <= 3'b111;
        end else begin
            sck_sync  <= {sck_sync[1:0], SCK};
            ssel_sync <= {ssel_sync[1:0], SSEL};
        end
    end

    // Edges come from stages 2/3 only; stage 1 may still be metastable.
    assign sck_rise    =  sck_sync[1]  & ~sck_sync[2];
    assign sck_fall    = ~sck_sync[1]  &  sck_sync[2];
    assign ssel_fall   = ~ssel_sync[1] &  ssel_sync[2];
    assign ssel_rise   =  ssel_sync[1] & ~ssel_sync[2];
    assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
    assign launch_edge = SAMPLE_RISE ? sck_fall : sck_rise;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control decode.
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        load_req  = 1'b0;
        shift_req = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (ssel_fall) begin
                    state_nxt = ACTIVE;
                    load_req  = 1'b1;
                    cnt_clr   = 1'b1;
                end
            end
            ACTIVE: begin
                if (ssel_rise) begin
                    // Frame aborted or ended: a partial word is simply dropped.
                    state_nxt = IDLE;
                    cnt_clr   = 1'b1;
                end else begin
                    cnt_inc = sample_edge;
                    if (launch_edge) begin
                        if (pending_load) begin
                            load_req = 1'b1;
                        end else if (bit_cnt != '0) begin
                            shift_req = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit counter, word-boundary bookkeeping, shift register and underrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt      <= '0;
            pending_load <= 1'b0;
            shreg        <= '0;
            word_sent    <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            word_sent <= 1'b0;

            if (cnt_clr) begin
                bit_cnt      <= '0;
                pending_load <= 1'b0;
            end else if (cnt_inc) begin
                if (bit_cnt == CNT_LAST) begin
                    bit_cnt      <= '0;
                    pending_load <= 1'b1;
                    word_sent    <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end else if (load_req) begin
                pending_load <= 1'b0;
            end

            if (load_req) begin
                shreg <= fifo_empty ? IDLE_FILL : fifo_rd_data;
            end else if (shift_req) begin
                shreg <= MSB_FIRST ? {shreg[DATA_W-2:0], 1'b1} : {1'b1, shreg[DATA_W-1:1]};
            end

            // Setting wins over a coincident clear.
            if (load_req && fifo_empty) begin
                underrun <= 1'b1;
            end else if (clr_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

    assign MISO    = MSB_FIRST ? shreg[DATA_W-1] : shreg[0];
    assign MISO_oe = (state == ACTIVE);

endmodule

// File: doc/spi_slave_tx.md
SPI_SLAVE_TX -- requirements
Module: spi_slave_tx

Interface
REQ-001 Parameter DATA_W, 8, bits per SPI word (4..32).
REQ-002 Parameter FIFO_DEPTH, 4, transmit FIFO entries (power of two, 2..64).
REQ-003 Parameter CPOL, 0, SCK idle level.
REQ-004 Parameter CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-005 Parameter MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first.
REQ-006 Parameter IDLE_FILL, all ones, word sent when the FIFO is empty.
REQ-007 Port clk input 1, single system clock; all logic on its rising edge.
REQ-008 Port rst input 1, reset, asynchronous and active-high.
REQ-009 Port SCK input 1, SPI clock, asynchronous to clk.
REQ-010 Port SSEL input 1, slave select, active low, asynchronous.
REQ-011 Port MISO output 1, serial data out.
REQ-012 Port MISO_oe output 1, tri-state enable for MISO; high while synchronised SSEL is active.
REQ-013 Port wr_data input DATA_W, word to enqueue.
REQ-014 Port wr_valid input 1, enqueue request.
REQ-015 Port wr_ready output 1, FIFO not full.
REQ-016 Port word_sent output 1, one-clk pulse per completed word.
REQ-017 Port underrun output 1, sticky flag: IDLE_FILL was loaded.
REQ-018 Port clr_underrun input 1, clears underrun.
REQ-019 Port fifo_level output $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-020 SCK and SSEL shall each pass through a 3-stage shift register; edges shall be detected on stages 2/3 only.
REQ-021 The leading edge shall be rising when CPOL=0 and falling when CPOL=1; the sample edge shall be the leading edge when CPHA=0 and the trailing edge otherwise; the other edge shall be the launch edge.
REQ-022 SCK high and low phases shall each be at least 3 clk periods; faster SCK is out of scope.
REQ-023 The state machine shall have states IDLE (SSEL inactive) and ACTIVE.
REQ-024 On an SSEL falling edge (IDLE->ACTIVE), the block shall load the shift register from the FIFO head (pop) and clear bit_cnt and pending_load.
REQ-025 Each sample edge in ACTIVE shall increment bit_cnt modulo DATA_W; on wrap to 0, the block shall pulse word_sent on the following clk and set pending_load.
REQ-026 On each launch edge: if pending_load, load the next word and clear pending_load; else if bit_cnt!=0, shift one bit; else do nothing.
REQ-027 MISO shall equal shift register bit DATA_W-1 when MSB_FIRST=1, bit 0 otherwise; shifting fills with 1.
REQ-028 A load with an empty FIFO shall use IDLE_FILL, pop nothing, and set underrun.
REQ-029 On an SSEL rising edge (ACTIVE->IDLE), the block shall discard any partial word, emit no word_sent, clear bit_cnt and pending_load, and leave the FIFO untouched.
REQ-030 A write shall occur when wr_valid and wr_ready are both high; a write while full shall be ignored.
REQ-031 A simultaneous write and pop on a non-empty FIFO shall leave fifo_level unchanged.
REQ-032 A pop on an empty FIFO with a simultaneous write shall load IDLE_FILL (no bypass); the written word shall be enqueued.
REQ-033 When set and clear coincide, clr_underrun shall lose and underrun shall remain 1.
REQ-034 Latency from a SCK pin edge to the MISO change shall be at most 4 clk cycles.

Reset
REQ-035 While rst=1: MISO=0, MISO_oe=0, wr_ready=1, word_sent=0, underrun=0, fifo_level=0, state=IDLE, synchronisers at idle levels (SCK=CPOL, SSEL=1).
REQ-036 Reset asserted mid-word shall flush the FIFO and abort the word; after release, no edge shall be detected until a genuine SSEL falling edge.

Structure
REQ-037 A shared package spi_pkg shall hold the state enum and the edge-select constants derived from CPOL/CPHA.
REQ-038 The FIFO shall be a sub-module spi_tx_fifo (parameters DATA_W, FIFO_DEPTH) with level output.

Verification
REQ-039 Mode 0, MSB first: enqueue 0xA5, SSEL low, 8 SCK cycles -> MISO bits 1,0,1,0,0,1,0,1 valid at each rising edge; one word_sent pulse.
REQ-040 Mode 3, LSB first: enqueue 0x3C,0x81, 16 SCK cycles in one frame -> bits of 0x3C then 0x81 LSB first; two word_sent pulses; fifo_level 2->0.
REQ-041 Empty FIFO, 8 SCK cycles -> MISO all 1; underrun=1 until clr_underrun pulse.
REQ-042 SSEL raised after 3 bits of 0x55 with 0x0F queued -> no word_sent; next frame sends 0x0F.
REQ-043 FIFO_DEPTH=4: write 5 words back-to-back -> wr_ready low after 4, fifo_level=4, 5th word dropped.
REQ-044 Assert rst mid-word with 2 words queued -> outputs at reset values; fifo_level=0.
